// File: rtl/apb_slave_reg_target.sv
// APB slave register-bank target: valid/ready request stream in, read data out
// after a programmable latency with a single read outstanding.
module apb_slave_reg_target #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    NUM_REGS   = 16,
   parameter int                    RD_LATENCY = 2,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5B0_0001,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic                  i_clk_apb,
   input  logic                  i_rstn_apb,
   input  logic                  i_valid,
   input  logic                  i_rd0_wr1,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid
);

   localparam int IW = ADDR_WIDTH - 2;
   localparam int RW = $clog2(NUM_REGS);
   localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t                             state_q, state_d;
   logic [CW-1:0]                      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]              cap_q, cap_d;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic                               ready_q, ready_d;
   logic                               rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0]              rd_data_q, rd_data_d;

   logic [IW-1:0]         idx;
   logic [RW-1:0]         ri;
   logic                  in_range;
   logic                  acc;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_addr_lsb;

   // Byte-lane bits carry no meaning for a word-only bank.
   assign unused_addr_lsb = ^i_addr[1:0];

   assign idx      = i_addr[ADDR_WIDTH-1:2];
   assign ri       = idx[RW-1:0];
   assign in_range = idx < IW'(NUM_REGS);
   assign acc      = i_valid & ready_q;
   assign rd_word  = !in_range ? ERR_DATA : (idx == '0) ? ID_VALUE : regs_q[ri];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cap_d      = cap_q;
      regs_d     = regs_q;
      ready_d    = ready_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (acc) begin
               if (i_rd0_wr1) begin
                  if (in_range && idx != '0) regs_d[ri] = i_wr_data;
               end else begin
                  cap_d   = rd_word;
                  cnt_d   = CW'(RD_LATENCY - 1);
                  ready_d = 1'b0;
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            ready_d = 1'b0;
            if (cnt_q == '0) begin
               rd_valid_d = 1'b1;
               rd_data_d  = cap_q;
               ready_d    = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      if (!i_rstn_apb) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cap_q      <= '0;
         regs_q     <= '0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cap_q      <= cap_d;
         regs_q     <= regs_d;
         ready_q    <= ready_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign o_ready    = ready_q;
   assign o_rd_valid = rd_valid_q;
   assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_apb_slave_reg_target.sv
// Directed bench for apb_slave_reg_target: reset, ID, write/read-back,
// out-of-range, backpressure and reset during a pending read.
module tb_apb_slave_reg_target;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        valid = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        ready;
   logic [31:0] rdata;
   logic        rvalid;

   int total = 0;
   int bad = 0;

   apb_slave_reg_target #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .RD_LATENCY(LAT),
      .ID_VALUE(32'hA5B0_0001), .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .i_clk_apb(clk), .i_rstn_apb(rstn), .i_valid(valid), .i_rd0_wr1(wr),
      .i_addr(addr), .i_wr_data(wdata), .o_ready(ready), .o_rd_data(rdata),
      .o_rd_valid(rvalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input string tag);
      chk({tag, "_rdy"}, 32'(ready), 32'd1);
      valid = 1'b1; wr = 1'b1; addr = a; wdata = d;
      tick();
      valid = 1'b0; wr = 1'b0;
   endtask

   // Accept a read, then check the exact response timing and data.
   task automatic do_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      int n = 0;
      while (!ready && n < 10) begin tick(); n++; end
      chk({tag, "_rdy"}, 32'(ready), 32'd1);
      valid = 1'b1; wr = 1'b0; addr = a;
      tick();
      valid = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         if (k < LAT) begin
            chk({tag, "_wait_vld"}, 32'(rvalid), 32'd0);
            chk({tag, "_wait_rdy"}, 32'(ready), 32'd0);
            tick();
         end else begin
            chk({tag, "_vld"}, 32'(rvalid), 32'd0);
            tick();
            chk({tag, "_vld"}, 32'(rvalid), 32'd1);
            chk({tag, "_data"}, rdata, exp);
            chk({tag, "_rdy_back"}, 32'(ready), 32'd1);
         end
      end
      tick();
      chk({tag, "_pulse_end"}, 32'(rvalid), 32'd0);
      chk({tag, "_hold"}, rdata, exp);
   endtask

   initial begin
      // Reset and idle
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_rdy", 32'(ready), 32'd0);
         chk("rst_vld", 32'(rvalid), 32'd0);
         chk("rst_data", rdata, 32'd0);
      end
      rstn = 1'b1;
      tick();
      chk("post_rst_rdy", 32'(ready), 32'd1);
      chk("post_rst_vld", 32'(rvalid), 32'd0);
      tick();
      chk("idle_vld", 32'(rvalid), 32'd0);

      do_rd(32'h0, 32'hA5B0_0001, "id");

      // Back-to-back write then read
      do_wr(32'h8, 32'h1234_5678, "wr8");
      do_rd(32'h8, 32'h1234_5678, "rd8");
      do_wr(32'h0, 32'hFFFF_FFFF, "wr0");
      do_rd(32'h0, 32'hA5B0_0001, "rd0_ro");

      // Out of range and address decode
      do_wr(32'h40, 32'h55, "wr40");
      do_rd(32'h40, 32'hDEAD_BEEF, "rd40");
      do_rd(32'h3C, 32'h0, "rd3c");
      do_rd(32'h9, 32'h1234_5678, "rd9");

      // Four consecutive writes
      do_wr(32'h4, 32'h11, "bb0");
      do_wr(32'h8, 32'h22, "bb1");
      do_wr(32'hC, 32'h33, "bb2");
      do_wr(32'h10, 32'h44, "bb3");

      // Two reads with i_valid held high across the wait
      valid = 1'b1; wr = 1'b0; addr = 32'h4;
      chk("bp_rdy0", 32'(ready), 32'd1);
      tick();                                   // edge N: first read accepted
      addr = 32'h10;
      chk("bp_rdy1", 32'(ready), 32'd0);
      chk("bp_vld1", 32'(rvalid), 32'd0);
      tick();                                   // N+1
      chk("bp_rdy2", 32'(ready), 32'd0);
      chk("bp_vld2", 32'(rvalid), 32'd0);
      tick();                                   // N+2: response
      chk("bp_vld3", 32'(rvalid), 32'd1);
      chk("bp_data3", rdata, 32'h11);
      chk("bp_rdy3", 32'(ready), 32'd1);
      tick();                                   // N+3: second read accepted
      valid = 1'b0;
      chk("bp_vld4", 32'(rvalid), 32'd0);
      chk("bp_rdy4", 32'(ready), 32'd0);
      tick();
      chk("bp_vld5", 32'(rvalid), 32'd0);
      tick();
      chk("bp_vld6", 32'(rvalid), 32'd1);
      chk("bp_data6", rdata, 32'h44);
      tick();
      chk("bp_vld7", 32'(rvalid), 32'd0);

      // Reset while a read is pending
      valid = 1'b1; wr = 1'b0; addr = 32'hC;
      chk("mr_rdy", 32'(ready), 32'd1);
      tick();
      valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("mr_rst_rdy", 32'(ready), 32'd0);
      chk("mr_rst_vld", 32'(rvalid), 32'd0);
      chk("mr_rst_data", rdata, 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_no_vld", 32'(rvalid), 32'd0);
      end
      do_rd(32'hC, 32'h0, "mr_rdc");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running want done");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/apb_slave_reg_target.md
Name: apb_slave_reg_target

Overview:
- Register-bank target on the request side of the APB slave arbiter.
- Consumes its valid/ready request stream (addr, write data, rd0_wr1) and returns read data with a one-cycle read-valid pulse.
- Holds NUM_REGS word registers. Register 0 is a read-only ID; out-of-range accesses return ERR_DATA.
- Read latency is programmable, with a single read outstanding, so the arbiter sees real backpressure through o_ready.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, byte address width.
- NUM_REGS, 16, number of word registers; power of 2, at least 2.
- RD_LATENCY, 2, edges from read acceptance to o_rd_valid; at least 1.
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0.
- ERR_DATA, 32'hDEAD_BEEF, data returned for out-of-range reads.

Ports:
- i_clk_apb  in  1  clock; all logic on the rising edge.
- i_rstn_apb  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid from the arbiter.
- i_rd0_wr1  in  1  0 = read, 1 = write.
- i_addr  in  ADDR_WIDTH  byte address.
- i_wr_data  in  DATA_WIDTH  write data.
- o_ready  out  1  target can accept a request this cycle.
- o_rd_data  out  DATA_WIDTH  read data, valid when o_rd_valid = 1.
- o_rd_valid  out  1  one-cycle read-response pulse.

Behaviour:
- Reset, asynchronous on i_rstn_apb = 0:
  - o_ready = 0, o_rd_valid = 0, o_rd_data = 0.
  - Registers 1..NUM_REGS-1 = 0; FSM = IDLE; latency counter = 0.
- o_ready is registered. It rises at the first rising edge after reset release.
- Transfer occurs at an edge where i_valid = 1 and o_ready = 1. i_valid with o_ready = 0 is ignored; the arbiter holds the request.
- Decode:
  - index = i_addr[ADDR_WIDTH-1:2]; i_addr[1:0] ignored.
  - In range iff index < NUM_REGS.
- FSM states: IDLE, RD_WAIT.
- IDLE, write accepted at edge N:
  - In range and index != 0: register[index] <= i_wr_data at edge N.
  - Index 0 or out of range: write silently dropped.
  - o_ready stays 1, so back-to-back writes are accepted every cycle.
  - No o_rd_valid is produced.
- IDLE, read accepted at edge N:
  - At edge N: capture the data, o_ready <= 0, counter <= RD_LATENCY-1, go to RD_WAIT.
  - Captured data is ID_VALUE for index 0, ERR_DATA if out of range, otherwise register[index] as of edge N. A write accepted at edge N-1 is visible.
- RD_WAIT:
  - The counter decrements each edge.
  - At the edge where the counter equals 0 (edge N+RD_LATENCY): o_rd_valid <= 1, o_rd_data <= captured data, o_ready <= 1, go to IDLE.
  - Earliest next accept is edge N+RD_LATENCY+1.
- o_rd_valid is high for exactly one cycle per read.
- o_rd_data holds the last read value until the next read response.
- With RD_LATENCY = 1: data at edge N+1, and o_ready is low for one cycle only.
- Registers are not writable while in RD_WAIT; no request can be accepted there.
- Reset during RD_WAIT: the pending read is discarded and no o_rd_valid pulse is ever emitted for it. Post-reset state is as above.
- No internal combinational path from i_valid to o_ready.

Test Plan:
- Reset then idle: i_rstn_apb low for 3 cycles, release -> all outputs 0 during reset; o_ready = 1 after the first edge post-release; o_rd_valid stays 0.
- ID register: read addr 0x0 accepted at edge N -> o_rd_valid = 1 and o_rd_data = 0xA5B0_0001 after edge N+2. o_ready low after edges N and N+1, high again after edge N+2.
- Write/read-back:
  - Stimulus: write 0x1234_5678 to 0x8 (edge N), then read 0x8 at edge N+1.
  - Required: 0x1234_5678 returned after edge N+3.
  - Then write 0xFFFF_FFFF to 0x0 and read 0x0 -> still 0xA5B0_0001.
- Out of range with NUM_REGS = 16:
  - Write 0x55 to 0x40, then read 0x40 -> 0xDEAD_BEEF.
  - Read 0x3C -> 0. Register 15 is unaffected by the 0x40 write.
  - Read 0x9 -> same data as 0x8 (low address bits ignored).
- Backpressure and back-to-back:
  - Stimulus: 4 consecutive writes to 0x4, 0x8, 0xC, 0x10; then a read of 0x4 with i_valid held high.
  - Required: all 4 writes accepted on consecutive edges. The second read is not accepted until the edge after o_rd_valid. Exactly one o_rd_valid pulse per read.
- Reset mid-read: read 0xC accepted at edge N, i_rstn_apb asserted between edges N and N+1, released 2 cycles later -> no o_rd_valid pulse; a subsequent read of 0xC returns 0.
